// File: rtl/dm_store_queue_pkg.sv
// Shared types and constants for the data-memory store queue: entry layout,
// sequencer state encoding, byte-enable lane encodings and the lane-merge helper.
package dm_store_queue_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BE_W    = 4;
  localparam int WADDR_W = ADDR_W - 2;

  localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;
  localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;
  localparam logic [BE_W-1:0] BE_BYTE1   = 4'b0010;
  localparam logic [BE_W-1:0] BE_BYTE2   = 4'b0100;
  localparam logic [BE_W-1:0] BE_BYTE3   = 4'b1000;

  typedef enum logic {
    SQ_IDLE = 1'b0,
    SQ_REQ  = 1'b1
  } sq_state_t;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [BE_W-1:0]    byteen;
    logic [DATA_W-1:0]  data;
  } sq_entry_t;

  // Fold a new store into an existing entry: enables accumulate, enabled lanes take the new data.
  function automatic sq_entry_t sq_merge(sq_entry_t e, logic [BE_W-1:0] be, logic [DATA_W-1:0] d);
    sq_entry_t r;
    r        = e;
    r.byteen = e.byteen | be;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) r.data[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_store_queue_if.sv
// Store/load/memory-bus signal bundle of the store queue; slave = queue side,
// master = M stage plus memory bus side.
interface dm_store_queue_if
  import dm_store_queue_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic               st_valid;
  logic [ADDR_W-1:0]  st_addr;
  logic [BE_W-1:0]    st_byteen;
  logic [DATA_W-1:0]  st_wdata;
  logic               st_ready;
  logic               ld_valid;
  logic [ADDR_W-1:0]  ld_addr;
  logic               ld_stall;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BE_W-1:0]    mem_byteen;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_ack;
  logic [PTR_W:0]     sq_count;
  logic               sq_empty;

  modport slave (
    input  st_valid, st_addr, st_byteen, st_wdata, ld_valid, ld_addr, mem_ack,
    output st_ready, ld_stall, mem_req, mem_addr, mem_byteen, mem_wdata, sq_count, sq_empty
  );

  modport master (
    output st_valid, st_addr, st_byteen, st_wdata, ld_valid, ld_addr, mem_ack,
    input  st_ready, ld_stall, mem_req, mem_addr, mem_byteen, mem_wdata, sq_count, sq_empty
  );

endinterface

// File: rtl/dm_sq_match.sv
// DEPTH-wide word-address comparator: flags every valid entry whose word address equals key.
module dm_sq_match
  import dm_store_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]              valid,
  input  logic [DEPTH-1:0][WADDR_W-1:0] waddrs,
  input  logic [WADDR_W-1:0]            key,
  output logic [DEPTH-1:0]              hit
);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = valid[i] && (waddrs[i] == key);
    end
  end

endmodule

// File: rtl/dm_store_queue.sv
// Posted-write store queue: accepts byte-enabled stores, drains them in order over req/ack,
// stalls loads to pending words. Define DM_SQ_MERGE_EN to merge into the youngest entry.
module dm_store_queue
  import dm_store_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  dm_store_queue_if.slave sq
);

  localparam int             PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_COUNT  = (PTR_W+1)'(1);

  sq_entry_t                     entries [DEPTH];
  logic [DEPTH-1:0]              valid;
  logic [DEPTH-1:0][WADDR_W-1:0] waddrs;
  logic [DEPTH-1:0]              ld_hit;
  logic [PTR_W-1:0]              wr_ptr, rd_ptr, young_ptr, next_ptr, load_ptr;
  logic [PTR_W:0]                count;
  sq_state_t                     state;
  logic                          full, merge_hit, accept, alloc, pop;
  sq_entry_t                     load_ent;
  logic                          unused_lsbs;

  assign young_ptr = wr_ptr - 1'b1;
  assign next_ptr  = rd_ptr + 1'b1;
  assign full      = (count == FULL_COUNT);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) waddrs[i] = entries[i].waddr;
  end

  dm_sq_match #(.DEPTH(DEPTH)) u_ld_match (
    .valid  (valid),
    .waddrs (waddrs),
    .key    (sq.ld_addr[ADDR_W-1:2]),
    .hit    (ld_hit)
  );

  assign sq.ld_stall = sq.ld_valid && (|ld_hit);

`ifdef DM_SQ_MERGE_EN
  logic [DEPTH-1:0] st_hit;
  sq_entry_t        merged;
  logic             merge_do;

  dm_sq_match #(.DEPTH(DEPTH)) u_st_match (
    .valid  (valid),
    .waddrs (waddrs),
    .key    (sq.st_addr[ADDR_W-1:2]),
    .hit    (st_hit)
  );

  // The entry already on the bus must stay frozen, so it is never a merge target.
  assign merge_hit = st_hit[young_ptr] && !((state == SQ_REQ) && (young_ptr == rd_ptr));
  assign merged    = sq_merge(entries[young_ptr], sq.st_byteen, sq.st_wdata);
  assign merge_do  = accept && merge_hit;
`else
  assign merge_hit = 1'b0;
`endif

  assign sq.st_ready = !full || merge_hit;
  assign accept      = sq.st_valid && sq.st_ready && (sq.st_byteen != '0);
  assign alloc       = accept && !merge_hit;
  assign pop         = (state == SQ_REQ) && sq.mem_ack;
  assign load_ptr    = (state == SQ_IDLE) ? rd_ptr : next_ptr;

  // Entry about to be copied to the bus registers; forwards a merge landing on it this cycle.
  always_comb begin
    // NOTE: default first so every path assigns load_ent and no latch is inferred.
    load_ent = entries[load_ptr];
`ifdef DM_SQ_MERGE_EN
    if (merge_do && (load_ptr == young_ptr)) load_ent = merged;
`endif
  end

  // NOTE: payload storage is not reset; the valid bits alone decide what is pending.
  always_ff @(posedge clk) begin
    if (alloc) begin
      entries[wr_ptr] <= '{waddr: sq.st_addr[ADDR_W-1:2], byteen: sq.st_byteen, data: sq.st_wdata};
    end
`ifdef DM_SQ_MERGE_EN
    if (merge_do) entries[young_ptr] <= merged;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      state         <= SQ_IDLE;
      sq.mem_req    <= 1'b0;
      sq.mem_addr   <= '0;
      sq.mem_byteen <= '0;
      sq.mem_wdata  <= '0;
    end else begin
      if (alloc) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= next_ptr;
      end
      case ({alloc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      case (state)
        SQ_IDLE: begin
          if (count != '0) begin
            state         <= SQ_REQ;
            sq.mem_req    <= 1'b1;
            sq.mem_addr   <= {load_ent.waddr, 2'b00};
            sq.mem_byteen <= load_ent.byteen;
            sq.mem_wdata  <= load_ent.data;
          end
        end
        SQ_REQ: begin
          if (sq.mem_ack) begin
            if (count > ONE_COUNT) begin
              sq.mem_addr   <= {load_ent.waddr, 2'b00};
              sq.mem_byteen <= load_ent.byteen;
              sq.mem_wdata  <= load_ent.data;
            end else begin
              state      <= SQ_IDLE;
              sq.mem_req <= 1'b0;
            end
          end
        end
        default: state <= SQ_IDLE;
      endcase
    end
  end

  assign sq.sq_count  = count;
  assign sq.sq_empty  = (count == '0);
  assign unused_lsbs  = ^{sq.st_addr[1:0], sq.ld_addr[1:0]};

endmodule

// File: doc/dm_store_queue.md
Name: dm_store_queue

Overview:
- Posted-write queue and sequencer in front of the data memory port.
- The M stage hands over byte-enabled stores (word address, 4-bit byteen, lane-aligned data from the store-lane formatter) and continues without waiting.
- The block drains stores in order to the memory bus with a req/ack handshake.
- It stalls M-stage loads that hit a word still pending in the queue, so loads never read stale data.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- st_valid  input  1  M stage presents a store this cycle.
- st_addr  input  32  store byte address; only [31:2] is stored.
- st_byteen  input  4  lane enables.
- st_wdata  input  32  lane-aligned write data.
- st_ready  output  1  queue can accept; equals !full.
- ld_valid  input  1  M stage presents a load this cycle.
- ld_addr  input  32  load byte address.
- ld_stall  output  1  combinational; load word matches a pending entry.
- mem_req  output  1  write request to the memory bus.
- mem_addr  output  32  {entry word address, 2'b00}.
- mem_byteen  output  4  entry byteen.
- mem_wdata  output  32  entry data.
- mem_ack  input  1  memory accepted the write this cycle.
- sq_count  output  PTR_W+1  number of occupied entries, including the one in flight.
- sq_empty  output  1  sq_count==0.

Behaviour:
- Reset values: all entries invalid; wr_ptr, rd_ptr and sq_count are 0; FSM is IDLE; mem_req=0; sq_empty=1; st_ready=1; mem_addr, mem_byteen and mem_wdata are 0.
- Push: on st_valid && st_ready && st_byteen!=0, write the entry at wr_ptr and increment wr_ptr modulo DEPTH.
- Zero-byteen stores are dropped and no entry is created.
- Full: st_ready=0 while sq_count==DEPTH. A pop in the same cycle does not open a slot until the next cycle; there is no full-bypass.
- FSM IDLE: if !sq_empty, go to REQ on the next edge. Push-to-mem_req latency is 2 cycles from an empty queue.
- FSM REQ:
  - mem_req=1 with the entry at rd_ptr driven from registers.
  - Address, byteen and data stay stable until mem_ack.
  - On mem_ack: pop (rd_ptr+1 mod DEPTH, invalidate the entry). Stay in REQ if another entry remains after the pop, else go to IDLE.
  - Back-to-back acks therefore give one write per cycle.
- Simultaneous push and pop: sq_count is unchanged; both pointers advance; wrap-around is handled by PTR_W-bit modulo pointers plus the count.
- ld_stall = ld_valid && (any valid entry with entry.addr[31:2]==ld_addr[31:2]).
  - Matching includes the in-flight entry.
  - Matching ignores byteen: any overlap at word granularity stalls.
  - A store pushed in the same cycle is not yet visible. The hazard unit already orders M-stage st/ld, so this is not a case.
- mem_ack while mem_req=0 is ignored.
- Reset mid-transaction: mem_req drops asynchronously and all pending stores are discarded. The bus must tolerate an abandoned request.

Optional Feature:
- Macro: DM_SQ_MERGE_EN.
- When defined, a push whose word address matches the youngest valid entry merges into it instead of allocating a new entry. This applies only if that entry is not the one currently presented on mem_req.
  - Merge rule: byteen |= st_byteen; data lanes with a set st_byteen bit are overwritten.
  - A merge is allowed even when the queue is full: st_ready = !full || merge_hit.
- When not defined, every non-zero-byteen store allocates an entry and st_ready = !full.

Decomposition:
- Shared package/constants header: entry field widths, FSM state encodings (SQ_IDLE, SQ_REQ), and the byteen encodings for the word, half and byte lanes.
- One natural sub-module, dm_sq_match: a DEPTH-wide word-address comparator with a valid mask. It serves both ld_stall and the merge hit, and outputs a per-entry hit vector.

Test Plan:
- Single store, ack held low for 3 cycles:
  - Stimulus: push addr 0x0000_0010, byteen 4'b1111, data 0xDEADBEEF; mem_ack held low 3 cycles.
  - Response: mem_req rises 2 cycles after the push and holds stable; on ack, sq_empty=1 and mem_req=0 the next cycle.
- Fill to full with mem_ack=0:
  - Stimulus: push 4 stores, then mem_ack=0.
  - Response: st_ready=0 and sq_count=4; a 5th st_valid is not accepted; one ack brings sq_count to 3 and st_ready=1 the following cycle.
- Load hazard:
  - Stimulus: pending byte store to 0x104 (byteen 4'b0010); load 0x106.
  - Response: ld_stall=1 until that entry is acked; a load to 0x108 gives ld_stall=0 throughout.
- Ordering, back-to-back acks, pointer wrap:
  - Stimulus: 6 stores with interleaved pushes and continuous mem_ack=1.
  - Response: memory sees exactly the push order at 1 write/cycle; pointers wrap past DEPTH-1 correctly.
- Reset mid-operation:
  - Stimulus: assert reset while mem_req=1 with 3 entries queued.
  - Response: mem_req=0, sq_count=0, sq_empty=1 immediately (asynchronous); no write is issued after reset release.
- With DM_SQ_MERGE_EN:
  - Stimulus: sh to 0x20 (byteen 4'b0011, data 0x0000_1234) while the head entry is in flight; then sb to 0x23 (byteen 4'b1000, data 0xAB00_0000).
  - Response: one entry remains with byteen 4'b1011 and data 0xAB00_1234; sq_count is unchanged by the second push.
